ls_sequencer: RTL and testbench

- Load/store control unit that drives the `rf` load/store datapath from the instruction side.
- Accepts one 32-bit RISC-V LD/SD instruction per valid/ready handshake and decodes it into rf control fields: base register, source register, destination register, sign-extended offset and load/store select.
- Strobes the rf enable for one cycle, waits out the memory latency, then reports completion.
- Sits between instruction fetch/issue and `rf`. Keeps per-type completion counters for the bench and for debug.

---
 rtl/ls_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ls_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_sequencer.sv
// ls_sequencer: accepts one RISC-V LD/SD per handshake, decodes it into rf
// control fields, strobes rf enable for one cycle, waits out the memory
// latency and then pulses done. Rejected words pulse illegal instead.
module ls_sequencer #(
    parameter int BITS    = 63,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic             rf_enable,
    output logic             rf_load_store,
    output logic [4:0]       rf_ra,
    output logic [4:0]       rf_rb,
    output logic [4:0]       rf_rw,
    output logic [BITS:0]    rf_imm,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Last WAIT count value; unused when MEM_LAT is 0 since EXEC skips WAIT.
    localparam logic [3:0] WAIT_LAST = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    state_t         state_reg, state_next;
    logic [3:0]     wait_cnt_reg, wait_cnt_next;
    logic           illegal_reg, illegal_next;
    logic [31:0]    instr_reg;
    logic           accept;
    logic           is_ld, is_sd;
    logic [11:0]    imm12;

    logic           rf_load_store_reg;
    logic [4:0]     rf_ra_reg, rf_rb_reg, rf_rw_reg;
    logic [BITS:0]  rf_imm_reg;

    assign accept = instr_valid && (state_reg == ST_IDLE);

    // Decode of the latched word: both LD and SD use funct3 = 011.
    assign is_ld = (instr_reg[6:0] == 7'b0000011) && (instr_reg[14:12] == 3'b011);
    assign is_sd = (instr_reg[6:0] == 7'b0100011) && (instr_reg[14:12] == 3'b011);
    assign imm12 = is_ld ? instr_reg[31:20] : {instr_reg[31:25], instr_reg[11:7]};

    // Next-state logic for the IDLE/DECODE/EXEC/WAIT/DONE sequence.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        illegal_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_ld || is_sd) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next   = ST_IDLE;
                    illegal_next = 1'b1;
                end
            end
            ST_EXEC: begin
                wait_cnt_next = 4'd0;
                state_next    = (MEM_LAT > 0) ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, wait counter and the one-cycle illegal pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            illegal_reg  <= illegal_next;
        end
    end

    // Capture the instruction word on the handshake edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_reg <= 32'd0;
        end else if (accept) begin
            instr_reg <= instr;
        end
    end

    // rf fields update only on a legal decode and hold until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_load_store_reg <= 1'b0;
            rf_ra_reg         <= 5'd0;
            rf_rb_reg         <= 5'd0;
            rf_rw_reg         <= 5'd0;
            rf_imm_reg        <= '0;
        end else if ((state_reg == ST_DECODE) && (is_ld || is_sd)) begin
            rf_load_store_reg <= is_ld;
            rf_rb_reg         <= instr_reg[19:15];
            rf_ra_reg         <= is_ld ? 5'd0 : instr_reg[24:20];
            rf_rw_reg         <= is_ld ? instr_reg[11:7] : 5'd0;
            rf_imm_reg        <= {{(BITS - 11){imm12[11]}}, imm12};
        end
    end

    // Saturating completion counters: index 0 counts loads, 1 counts stores.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             hit;
            assign hit = (state_reg == ST_DONE) && (rf_load_store_reg == (gi == 0));
            // Count the completion while in DONE, holding at all-ones.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (hit && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign instr_ready   = (state_reg == ST_IDLE);
    assign busy          = (state_reg != ST_IDLE);
    assign rf_enable     = (state_reg == ST_EXEC);
    assign done          = (state_reg == ST_DONE);
    assign illegal       = illegal_reg;
    assign rf_load_store = rf_load_store_reg;
    assign rf_ra         = rf_ra_reg;
    assign rf_rb         = rf_rb_reg;
    assign rf_rw         = rf_rw_reg;
    assign rf_imm        = rf_imm_reg;
    assign load_count    = g_cnt[0].cnt_reg;
    assign store_count   = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_ls_sequencer.sv
// Self-checking bench for ls_sequencer: instance A (MEM_LAT=1) runs a vector
// table and random traffic against a cycle-schedule reference model;
// instance B (MEM_LAT=0, CNT_W=2) covers back-to-back, abort and saturation.
module tb_ls_sequencer;

    localparam int BITS  = 63;
    localparam int LAT_A = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        a_reset, a_valid, a_ready, a_en, a_ls, a_busy, a_done, a_ill;
    logic [31:0] a_instr;
    logic [4:0]  a_ra, a_rb, a_rw;
    logic [63:0] a_imm;
    logic [15:0] a_lc, a_sc;

    // Instance B signals
    logic        b_reset, b_valid, b_ready, b_en, b_ls, b_busy, b_done, b_ill;
    logic [31:0] b_instr;
    logic [4:0]  b_ra, b_rb, b_rw;
    logic [63:0] b_imm;
    logic [1:0]  b_lc, b_sc;

    ls_sequencer #(.BITS(BITS), .MEM_LAT(LAT_A), .CNT_W(16)) dut_a (
        .clk(clk), .reset(a_reset), .instr_valid(a_valid), .instr_ready(a_ready),
        .instr(a_instr), .rf_enable(a_en), .rf_load_store(a_ls), .rf_ra(a_ra),
        .rf_rb(a_rb), .rf_rw(a_rw), .rf_imm(a_imm), .busy(a_busy), .done(a_done),
        .illegal(a_ill), .load_count(a_lc), .store_count(a_sc)
    );

    ls_sequencer #(.BITS(BITS), .MEM_LAT(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(b_reset), .instr_valid(b_valid), .instr_ready(b_ready),
        .instr(b_instr), .rf_enable(b_en), .rf_load_store(b_ls), .rf_ra(b_ra),
        .rf_rb(b_rb), .rf_rw(b_rw), .rf_imm(b_imm), .busy(b_busy), .done(b_done),
        .illegal(b_ill), .load_count(b_lc), .store_count(b_sc)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic        ls;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic [63:0] imm;
    } vec_t;

    vec_t vecs[6];

    // Reference model: cycle numbers of the scheduled events for instance A.
    int          cyc, m_free, m_en, m_done, m_ill;
    logic        e_ls, p_ls;
    logic [4:0]  e_ra, e_rb, e_rw, p_ra, p_rb, p_rw;
    logic [63:0] e_imm, p_imm;
    int          e_lc, e_sc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Instruction meaning written from the ISA field layout with integer math.
    function automatic void decode(input logic [31:0] w, output logic legal, output logic ls,
                                   output logic [4:0] ra, output logic [4:0] rb,
                                   output logic [4:0] rw, output logic [63:0] imm);
        int off;
        legal = (w[14:12] == 3'd3) && (w[6:0] == 7'h03 || w[6:0] == 7'h23);
        ls = 1'b0; ra = 5'd0; rb = 5'd0; rw = 5'd0; imm = 64'd0; off = 0;
        if (legal) begin
            ls = (w[6:0] == 7'h03);
            rb = w[19:15];
            if (ls) begin
                rw  = w[11:7];
                off = int'(w[31:20]);
            end else begin
                ra  = w[24:20];
                off = int'(w[31:25]) * 32 + int'(w[11:7]);
            end
            if (off >= 2048) off = off - 4096;
            imm = 64'(longint'(off));
        end
    endfunction

    task automatic model_accept(input logic [31:0] w);
        logic legal;
        decode(w, legal, p_ls, p_ra, p_rb, p_rw, p_imm);
        $display("txn A cyc=%0d instr=%08h legal=%0d", cyc, w, legal);
        if (legal) begin
            m_en   = cyc + 2;
            m_done = cyc + 3 + LAT_A;
            m_free = cyc + 4 + LAT_A;
        end else begin
            m_ill  = cyc + 2;
            m_free = cyc + 2;
        end
    endtask

    // Drive A for one cycle, advance the model, compare every output.
    task automatic step_a(input logic v, input logic [31:0] w);
        a_valid = v;
        a_instr = w;
        if (v && cyc >= m_free) model_accept(w);
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == m_en) begin
            e_ls = p_ls; e_ra = p_ra; e_rb = p_rb; e_rw = p_rw; e_imm = p_imm;
        end
        if (cyc == m_done + 1) begin
            if (p_ls) e_lc++;
            else e_sc++;
        end
        check("a_ready",  64'(a_ready), 64'(cyc >= m_free));
        check("a_busy",   64'(a_busy),  64'(cyc < m_free));
        check("a_enable", 64'(a_en),    64'(cyc == m_en));
        check("a_done",   64'(a_done),  64'(cyc == m_done));
        check("a_illegal",64'(a_ill),   64'(cyc == m_ill));
        check("a_ls",     64'(a_ls),    64'(e_ls));
        check("a_ra",     64'(a_ra),    64'(e_ra));
        check("a_rb",     64'(a_rb),    64'(e_rb));
        check("a_rw",     64'(a_rw),    64'(e_rw));
        check("a_imm",    a_imm,        e_imm);
        check("a_load_count",  64'(a_lc), 64'(e_lc));
        check("a_store_count", 64'(a_sc), 64'(e_sc));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 2))
            0: begin w[6:0] = 7'b0000011; w[14:12] = 3'b011; end
            1: begin w[6:0] = 7'b0100011; w[14:12] = 3'b011; end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        int exp_sat[5];
        logic seen;
        logic b_en_seen;

        vecs[0] = '{32'h01013283, 1'b1, 1'b1, 5'd0,  5'd2,  5'd5,  64'd16};
        vecs[1] = '{32'hFE71BC23, 1'b1, 1'b0, 5'd7,  5'd3,  5'd0,  64'hFFFF_FFFF_FFFF_FFF8};
        vecs[2] = '{32'h00000013, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  64'd0};
        vecs[3] = '{32'hFFF03F83, 1'b1, 1'b1, 5'd0,  5'd0,  5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{32'h7FFFBFA3, 1'b1, 1'b0, 5'd31, 5'd31, 5'd0,  64'd2047};
        vecs[5] = '{32'h01012283, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  64'd0};
        exp_sat = '{1, 2, 3, 3, 3};

        // ---------------- instance A: reset with instr_valid held ----------
        cyc = 0;
        a_reset = 1'b1; a_valid = 1'b1; a_instr = 32'h01013283;
        b_reset = 1'b1; b_valid = 1'b0; b_instr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",    64'(a_busy), 64'd0);
        check("rst_ready",   64'(a_ready), 64'd1);
        check("rst_enable",  64'(a_en),   64'd0);
        check("rst_done",    64'(a_done), 64'd0);
        check("rst_illegal", 64'(a_ill),  64'd0);
        check("rst_imm",     a_imm,       64'd0);
        check("rst_counts",  64'({a_lc, a_sc}), 64'd0);
        a_reset = 1'b0; a_valid = 1'b0;
        m_free = 0; m_en = -100; m_done = -100; m_ill = -100;
        e_ls = 1'b0; e_ra = 5'd0; e_rb = 5'd0; e_rw = 5'd0; e_imm = 64'd0;
        p_ls = 1'b0; p_ra = 5'd0; p_rb = 5'd0; p_rw = 5'd0; p_imm = 64'd0;
        e_lc = 0; e_sc = 0;

        // ---------------- instance A: vector table -------------------------
        for (int i = 0; i < 6; i++) begin
            while (cyc < m_free) step_a(1'b0, $urandom);
            step_a(1'b1, vecs[i].instr);
            step_a(1'b0, $urandom);
            if (vecs[i].legal) begin
                check("vec_enable", 64'(a_en), 64'd1);
                check("vec_ls",     64'(a_ls), 64'(vecs[i].ls));
                check("vec_ra",     64'(a_ra), 64'(vecs[i].ra));
                check("vec_rb",     64'(a_rb), 64'(vecs[i].rb));
                check("vec_rw",     64'(a_rw), 64'(vecs[i].rw));
                check("vec_imm",    a_imm,     vecs[i].imm);
            end else begin
                check("vec_illegal", 64'(a_ill),   64'd1);
                check("vec_noen",    64'(a_en),    64'd0);
                check("vec_ready",   64'(a_ready), 64'd1);
            end
        end

        // ---------------- instance A: random traffic -----------------------
        for (int i = 0; i < 400; i++) begin
            step_a($urandom_range(0, 99) < 60, rand_instr());
        end
        a_valid = 1'b0;

        // ---------------- instance B: back-to-back, MEM_LAT=0 --------------
        b_valid = 1'b1; b_instr = 32'h01013283;
        @(posedge clk); #1;
        b_reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            $display("txn B b2b cyc=%0d en=%0d done=%0d ready=%0d", k, b_en, b_done, b_ready);
            check("b2b_enable", 64'(b_en),    64'(k == 2 || k == 6));
            check("b2b_done",   64'(b_done),  64'(k == 3 || k == 7));
            check("b2b_ready",  64'(b_ready), 64'(k == 4 || k == 8));
            if (k == 4) check("b2b_load_count", 64'(b_lc), 64'd1);
            if (k == 6) begin
                check("b2b_ls", 64'(b_ls), 64'd0);
                check("b2b_ra", 64'(b_ra), 64'd7);
            end
            if (k == 8) check("b2b_store_count", 64'(b_sc), 64'd1);
            if (k == 1) b_instr = 32'hFE71BC23;
            if (k == 5) b_valid = 1'b0;
        end

        // ---------------- instance B: reset during EXEC --------------------
        b_reset = 1'b1;
        @(posedge clk); #1;
        b_reset = 1'b0; b_valid = 1'b1; b_instr = 32'h01013283;
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_enable_exec", 64'(b_en), 64'd1);
        b_reset = 1'b1;
        @(posedge clk); #1;
        b_reset = 1'b0;
        check("abort_enable_drop", 64'(b_en),    64'd0);
        check("abort_busy",        64'(b_busy),  64'd0);
        check("abort_ready",       64'(b_ready), 64'd1);
        b_en_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("abort_no_done", 64'(b_done), 64'd0);
            b_en_seen = b_en_seen | b_en;
            @(posedge clk); #1;
        end
        check("abort_no_enable", 64'(b_en_seen), 64'd0);
        check("abort_counts", 64'({b_lc, b_sc}), 64'd0);
        $display("txn B abort checked");

        // ---------------- instance B: saturation, CNT_W=2 ------------------
        for (int j = 0; j < 5; j++) begin
            b_valid = 1'b1; b_instr = 32'h01013283;
            seen = 1'b0;
            for (int n = 0; n < 12 && !seen; n++) begin
                @(posedge clk); #1;
                if (b_busy) b_valid = 1'b0;
                if (b_done) seen = 1'b1;
            end
            b_valid = 1'b0;
            check("sat_done_seen", 64'(seen), 64'd1);
            @(posedge clk); #1;
            $display("txn B sat load %0d load_count=%0d", j, b_lc);
            check("sat_load_count", 64'(b_lc), 64'(exp_sat[j]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
